// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer with frame-atomic outputs.
// Slots are staged in shadow registers and published together on slot 3.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             out_valid,
  output logic [1:0]       sel_o,
  output logic             frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic [WIDTH-1:0] y3_q, y3_d;
  logic             ov_q, ov_d;
  logic             fe_q, fe_d;

  // Next-state: slot sequencing, resync and frame publish.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    ov_d    = 1'b0;
    fe_d    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (in_sof) begin
            sh0_d   = in_data;
            sel_d   = 2'd1;
            state_d = RUN;
          end else begin
            fe_d = 1'b1;
          end
        end
        RUN: begin
          unique case (1'b1)
            in_sof: begin
              fe_d  = 1'b1;
              sh0_d = in_data;
              sel_d = 2'd1;
            end
            (sel_q == 2'd3): begin
              y0_d    = sh0_q;
              y1_d    = sh1_q;
              y2_d    = sh2_q;
              y3_d    = in_data;
              ov_d    = 1'b1;
              sel_d   = 2'd0;
              state_d = IDLE;
            end
            default: begin
              if (sel_q == 2'd1) sh1_d = in_data;
              else               sh2_d = in_data;
              sel_d = sel_q + 2'd1;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and data registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
    end
  end

  assign y0        = y0_q;
  assign y1        = y1_q;
  assign y2        = y2_q;
  assign y3        = y3_q;
  assign out_valid = ov_q;
  assign frame_err = fe_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4.
// Stimulus queues expected frames/errors; a negedge monitor checks them.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] y0, y1, y2, y3;
  logic       out_valid;
  logic [1:0] sel_o;
  logic       frame_err;

  typedef struct {
    logic [31:0] ys;
    int          cyc;
  } frm_t;

  frm_t        frm_q[$];
  int          err_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          pend_f = 0;
  bit          pend_e = 0;
  logic [31:0] pend_y;
  logic [31:0] hold_y = '0;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .sel_o(sel_o), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_y = '0;
    end else begin
      if (out_valid) begin
        if (frm_q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          frm_t f;
          f = frm_q.pop_front();
          chk("frame y", {y0, y1, y2, y3}, f.ys);
          chk("out_valid cycle", cyc, f.cyc);
          hold_y = f.ys;
        end
      end else begin
        chk("y hold", {y0, y1, y2, y3}, hold_y);
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected frame_err", 1, 0);
        end else begin
          chk("frame_err cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  task automatic expect_frame(input logic [31:0] ys);
    pend_f = 1;
    pend_y = ys;
  endtask

  task automatic expect_err();
    pend_e = 1;
  endtask

  // Drive one accepted sample; time is posedge+1 on entry and exit.
  task automatic send(input logic [7:0] d, input logic s,
                      input logic [1:0] sel_exp);
    frm_t f;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    if (pend_f) begin
      f.ys = pend_y;
      f.cyc = cyc + 1;
      frm_q.push_back(f);
      pend_f = 0;
    end
    if (pend_e) begin
      err_q.push_back(cyc + 1);
      pend_e = 0;
    end
    @(posedge clk); #1;
    chk("sel_o", {30'd0, sel_o}, {30'd0, sel_exp});
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_sof   = 1'bx;
  endtask

  task automatic idle(input int n, input logic [1:0] sel_exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("sel_o idle", {30'd0, sel_o}, {30'd0, sel_exp});
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " y"}, {y0, y1, y2, y3}, 32'h0);
    chk({nm, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, " frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({nm, " sel_o"}, {30'd0, sel_o}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1, 2'd0);

    // Basic frame
    send(8'hA5, 1, 2'd1);
    send(8'h3C, 0, 2'd2);
    send(8'h0F, 0, 2'd3);
    expect_frame(32'hA53C0FF0);
    send(8'hF0, 0, 2'd0);
    idle(2, 2'd0);

    // Gapped frame
    send(8'hA5, 1, 2'd1);
    idle(3, 2'd1);
    send(8'h3C, 0, 2'd2);
    idle(3, 2'd2);
    send(8'h0F, 0, 2'd3);
    idle(3, 2'd3);
    expect_frame(32'hA53C0FF0);
    send(8'hF0, 0, 2'd0);
    idle(2, 2'd0);

    // Early SOF resync
    send(8'h11, 1, 2'd1);
    send(8'h22, 0, 2'd2);
    expect_err();
    send(8'h33, 1, 2'd1);
    send(8'h44, 0, 2'd2);
    send(8'h55, 0, 2'd3);
    expect_frame(32'h33445566);
    send(8'h66, 0, 2'd0);
    idle(2, 2'd0);

    // Missing SOF
    expect_err();
    send(8'h77, 0, 2'd0);
    send(8'h01, 1, 2'd1);
    send(8'h02, 0, 2'd2);
    send(8'h03, 0, 2'd3);
    expect_frame(32'h01020304);
    send(8'h04, 0, 2'd0);
    idle(2, 2'd0);

    // Back-to-back frames
    send(8'h10, 1, 2'd1);
    send(8'h20, 0, 2'd2);
    send(8'h30, 0, 2'd3);
    expect_frame(32'h10203040);
    send(8'h40, 0, 2'd0);
    send(8'h50, 1, 2'd1);
    send(8'h60, 0, 2'd2);
    send(8'h70, 0, 2'd3);
    expect_frame(32'h50607080);
    send(8'h80, 0, 2'd0);
    idle(2, 2'd0);

    // Async reset mid-frame
    send(8'h11, 1, 2'd1);
    send(8'h22, 0, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    @(posedge clk); #1;
    chk_zero("reset held");
    rst_n = 1'b1;
    idle(1, 2'd0);
    expect_err();
    send(8'h99, 0, 2'd0);
    send(8'hC1, 1, 2'd1);
    send(8'hC2, 0, 2'd2);
    send(8'hC3, 0, 2'd3);
    expect_frame(32'hC1C2C3C4);
    send(8'hC4, 0, 2'd0);
    idle(3, 2'd0);

    chk("frames pending", frm_q.size(), 0);
    chk("errors pending", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
